// File: rtl/calc1_port_sequencer.sv
// calc1_port_sequencer: buffers host operations in a small FIFO and issues each
// one to a calc1 request port in the two-cycle (cmd+op1, op2) format, then waits
// for the port response (or a timeout) and hands code/data back to the host.
module calc1_port_sequencer #(
  parameter int DATA_W     = 32,
  parameter int CMD_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [CMD_W-1:0]  host_cmd,
  input  logic [DATA_W-1:0] host_op1,
  input  logic [DATA_W-1:0] host_op2,
  output logic [CMD_W-1:0]  req_cmd_out,
  output logic [DATA_W-1:0] req_data_out,
  input  logic [1:0]        out_resp,
  input  logic [DATA_W-1:0] out_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_code,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              stray_resp
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, CMD, OP2, WAIT, HOLD} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [CMD_W-1:0]  cur_cmd;
  logic [DATA_W-1:0] cur_op1;
  logic [DATA_W-1:0] cur_op2;

  logic [CMD_W-1:0]  f_cmd [FIFO_DEPTH];
  logic [DATA_W-1:0] f_op1 [FIFO_DEPTH];
  logic [DATA_W-1:0] f_op2 [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic push_acc;
  logic push;
  logic pop;

  // Readiness depends on occupancy only, so a pop in the same cycle never frees a slot early.
  assign host_ready = (count < DEPTH);
  assign push_acc   = host_valid & host_ready;
  // A zero command is handshaken but never stored, so it produces no response.
  assign push       = push_acc & (host_cmd != '0);
  assign pop        = (state == IDLE) & (count != '0);
  assign busy       = (state != IDLE) | (count != '0);

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge c_clk) begin
    if (push) begin
      f_cmd[wr_ptr] <= host_cmd;
      f_op1[wr_ptr] <= host_op1;
      f_op2[wr_ptr] <= host_op2;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Issue/response FSM; port outputs are registered from the current state, so they
  // trail the state by one cycle (cmd appears the cycle after entering CMD).
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= '0;
      cur_cmd      <= '0;
      cur_op1      <= '0;
      cur_op2      <= '0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_code     <= 2'b00;
      rsp_data     <= '0;
      stray_resp   <= 1'b0;
    end else begin
      if ((out_resp != 2'b00) && (state != WAIT)) stray_resp <= 1'b1;
      case (state)
        IDLE: begin
          req_cmd_out  <= '0;
          req_data_out <= '0;
          if (pop) begin
            cur_cmd <= f_cmd[rd_ptr];
            cur_op1 <= f_op1[rd_ptr];
            cur_op2 <= f_op2[rd_ptr];
            state   <= CMD;
          end
        end
        CMD: begin
          req_cmd_out  <= cur_cmd;
          req_data_out <= cur_op1;
          state        <= OP2;
        end
        OP2: begin
          req_cmd_out  <= '0;
          req_data_out <= cur_op2;
          timer        <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          req_cmd_out  <= '0;
          req_data_out <= '0;
          // A response on the expiry cycle wins over the timeout.
          if (out_resp != 2'b00) begin
            rsp_code  <= out_resp;
            rsp_data  <= out_data;
            rsp_valid <= 1'b1;
            state     <= HOLD;
          end else if (timer == TMAX) begin
            rsp_code  <= 2'b00;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
